busio: RTL and testbench
========================

BUSIO -- requirements
Module: busio

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-003 SHALL have port fetch_address, input, 32, instruction address requested by fetch (continuous request).
REQ-004 SHALL have port fetch_data, output, 32, fetched instruction word.
REQ-005 SHALL have port fetch_ready, output, 1, one-cycle pulse: fetch_data valid for fetch_address.
REQ-006 SHALL have ports mem_load and mem_store, input, 1 each, data access request from memory stage (never both high).
REQ-007 SHALL have ports mem_address (32) and mem_store_data (32), input.
REQ-008 SHALL have port mem_size, input, 2; 00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 SHALL have port mem_signed, input, 1; load sign-extension enable.
REQ-010 SHALL have ports mem_load_data (output, 32) and mem_ready (output, 1); mem_ready is a one-cycle completion pulse.
REQ-011 SHALL have ext_valid (out 1), ext_ready (in 1), ext_address (out 32), ext_write (out 1), ext_write_data (out 32), ext_write_strb (out 4), ext_read_data (in 32).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, MEM.
REQ-013 IDLE: if (mem_load or mem_store) and mem_ready low -> MEM; else if fetch_ready low -> FETCH; memory has priority over fetch.
REQ-014 No request SHALL be issued from IDLE in a cycle where fetch_ready or mem_ready is high (stale-request guard).
REQ-015 On entering FETCH/MEM, address, write data, strobes, size, signed and a fetch-address copy SHALL be latched; ext_* outputs driven from latches only.
REQ-016 ext_valid SHALL be high exactly in FETCH and MEM; ext_address/ext_write/ext_write_data/ext_write_strb stable while ext_valid high and ext_ready low.
REQ-017 Transfer completes in any cycle with ext_valid and ext_ready both high; ext_read_data sampled that cycle; FSM -> IDLE at that edge.
REQ-018 FETCH completion: fetch_data <= ext_read_data; fetch_ready pulses next cycle only if current fetch_address equals latched copy; otherwise data discarded, no pulse (branch redirect), refetch from IDLE.
REQ-019 MEM completion: mem_ready pulses next cycle; for loads mem_load_data <= extracted value.
REQ-020 ext_address SHALL be latched address with bits [1:0] forced to 00; ext_write high only for stores.
REQ-021 Store strobes: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111. Store data replicated: byte x4, half x2, word as-is.
REQ-022 Load extraction: select lane by addr[1:0] (byte) or addr[1] (half); zero-extend, or sign-extend when mem_signed; word unmodified.
REQ-023 Misalignment SHALL NOT be detected here; low address bits beyond the size are ignored.
REQ-024 Minimum latency with ext_ready tied high: request visible in IDLE cycle N, ext_valid cycle N+1, ready pulse cycle N+2.

Reset
REQ-025 While reset high: state IDLE; ext_valid, ext_write, fetch_ready, mem_ready 0; ext_write_strb 0000; fetch_data, mem_load_data, ext_address, ext_write_data 0.
REQ-026 Reset asserted mid-transfer SHALL drop ext_valid immediately (asynchronous abort); no ready pulse follows reset.

Verification
REQ-027 fetch_address 0x100, ext_ready tied 1, ext_read_data 0x00000013 -> ext_valid 1 cycle at 0x100, then fetch_ready 1-cycle pulse with fetch_data 0x00000013.
REQ-028 mem_store, size byte, address 0x203, data 0x000000AB -> ext_address 0x200, strb 1000, ext_write_data 0xABABABAB, ext_write 1, then mem_ready pulse.
REQ-029 mem_load, size half, signed, address 0x402, ext_read_data 0x80011234 -> mem_load_data 0xFFFF8001; unsigned -> 0x00008001.
REQ-030 Fetch in flight with ext_ready low 3 cycles, fetch_address changed 0x100->0x200 meanwhile -> no fetch_ready for 0x100; next ext_address 0x200.
REQ-031 mem_load and fetch pending together in IDLE -> MEM served first; ext_ready held low 2 cycles keeps all ext_* stable; reset asserted during wait -> ext_valid 0 same cycle, no mem_ready.

Source files
------------

// File: rtl/busio.sv
// Bus interface unit: arbitrates instruction fetch and load/store requests onto
// a single valid/ready external bus, with byte/half/word lane handling.
module busio (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        ext_valid,
  input  logic        ext_ready,
  output logic [31:0] ext_address,
  output logic        ext_write,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strb,
  input  logic [31:0] ext_read_data
);

  typedef enum logic [1:0] {IDLE, FETCH, MEM} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_write;
  logic [31:0] r_fetch_copy;
  logic [31:0] r_fetch_data;
  logic        r_fetch_ready;
  logic [31:0] r_load_data;
  logic        r_mem_ready;

  logic        w_idle_go;
  logic        w_mem_req;
  logic        w_done;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;

  // Lane select and sign/zero extension of a read word.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   extract = {{24{sg & b[7]}}, b};
      2'b01:   extract = {{16{sg & h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

  // A ready pulse still visible means its requester has not yet seen it, so a
  // request sampled now would be stale.
  assign w_idle_go = (r_state == IDLE) && !r_fetch_ready && !r_mem_ready;
  assign w_mem_req = mem_load | mem_store;
  assign w_done    = (r_state != IDLE) && ext_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_idle_go) w_next = w_mem_req ? MEM : FETCH;
      FETCH, MEM: if (ext_ready) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = mem_store_data;
    case (mem_size)
      2'b00: begin
        w_strb  = 4'b0001 << mem_address[1:0];
        w_wdata = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {mem_address[1], 1'b0};
        w_wdata = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the asynchronous reset clears every datapath register as well, since
  // all of them are observable outputs with defined reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_strb        <= '0;
      r_size        <= '0;
      r_signed      <= 1'b0;
      r_write       <= 1'b0;
      r_fetch_copy  <= '0;
      r_fetch_data  <= '0;
      r_fetch_ready <= 1'b0;
      r_load_data   <= '0;
      r_mem_ready   <= 1'b0;
    end else begin
      r_fetch_ready <= 1'b0;
      r_mem_ready   <= 1'b0;
      if (r_state == IDLE && w_next == MEM) begin
        r_addr   <= mem_address;
        r_write  <= mem_store;
        r_wdata  <= mem_store ? w_wdata : '0;
        r_strb   <= mem_store ? w_strb : 4'b0000;
        r_size   <= mem_size;
        r_signed <= mem_signed;
      end else if (r_state == IDLE && w_next == FETCH) begin
        r_addr   <= fetch_address;
        r_write  <= 1'b0;
        r_wdata  <= '0;
        r_strb   <= 4'b0000;
        r_size   <= 2'b10;
        r_signed <= 1'b0;
      end
      if (r_state == IDLE && w_next != IDLE) r_fetch_copy <= fetch_address;
      if (w_done) begin
        if (r_state == FETCH) begin
          r_fetch_data  <= ext_read_data;
          // A redirected fetch is dropped silently and reissued from IDLE.
          r_fetch_ready <= (fetch_address == r_fetch_copy);
        end else begin
          r_mem_ready <= 1'b1;
          if (!r_write) r_load_data <= extract(ext_read_data, r_addr[1:0], r_size, r_signed);
        end
      end
    end
  end

  assign ext_valid      = (r_state != IDLE);
  assign ext_address    = {r_addr[31:2], 2'b00};
  assign ext_write      = r_write;
  assign ext_write_data = r_wdata;
  assign ext_write_strb = r_strb;
  assign fetch_data     = r_fetch_data;
  assign fetch_ready    = r_fetch_ready;
  assign mem_load_data  = r_load_data;
  assign mem_ready      = r_mem_ready;

endmodule

// File: tb/tb_busio.sv
// Self-checking bench for busio: directed bus transactions with a scoreboard of
// expected fetch/load results popped whenever the DUT pulses a ready.
module tb_busio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_address = '0;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_address;
  logic        ext_write;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strb;
  logic [31:0] ext_read_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fq[$];
  logic [31:0] mq[$];
  logic [31:0] last_load = '0;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] ext_wdata;
    logic [31:0] load;
  } mem_op_t;

  mem_op_t ops[11];

  busio dut (
    .clk(clk), .reset(reset),
    .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
    .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_load_data(mem_load_data), .mem_ready(mem_ready),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_address(ext_address),
    .ext_write(ext_write), .ext_write_data(ext_write_data),
    .ext_write_strb(ext_write_strb), .ext_read_data(ext_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_ready) begin
        if (fq.size() == 0) check("spurious_fetch_ready", fetch_ready, 0);
        else                check("fetch_data", fetch_data, fq.pop_front());
      end
      if (mem_ready) begin
        if (mq.size() == 0) check("spurious_mem_ready", mem_ready, 0);
        else                check("mem_load_data", mem_load_data, mq.pop_front());
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ext_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_timeout"}, ext_valid, 1);
  endtask

  task automatic grant();
    ext_ready = 1'b1;
    @(negedge clk);
    ext_ready = 1'b0;
  endtask

  task automatic do_mem(input mem_op_t op, input int hold);
    logic [31:0] exp;
    mem_load       = !op.store;
    mem_store      = op.store;
    mem_address    = op.addr;
    mem_store_data = op.wdata;
    mem_size       = op.size;
    mem_signed     = op.sgn;
    ext_read_data  = op.rdata;
    wait_valid("mem");
    for (int h = 0; h <= hold; h++) begin
      check("mem_ext_address", ext_address, {op.addr[31:2], 2'b00});
      check("mem_ext_write", ext_write, op.store);
      if (op.store) begin
        check("mem_ext_strb", ext_write_strb, op.strb);
        check("mem_ext_wdata", ext_write_data, op.ext_wdata);
      end
      if (h < hold) begin
        @(negedge clk);
        mem_address    = ~op.addr;
        mem_store_data = ~op.wdata;
        mem_size       = ~op.size;
      end
    end
    if (!op.store) last_load = op.load;
    exp = last_load;
    mq.push_back(exp);
    grant();
    mem_load  = 1'b0;
    mem_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st  sz     sg   addr          wdata         rdata         strb     ext_wdata     load
    ops[0]  = '{1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_00AB, 32'h0,         4'b1000, 32'hABAB_ABAB, 32'h0};
    ops[1]  = '{1'b0, 2'b01, 1'b1, 32'h402, 32'h0,         32'h8001_1234, 4'b0000, 32'h0,         32'hFFFF_8001};
    ops[2]  = '{1'b0, 2'b01, 1'b0, 32'h402, 32'h0,         32'h8001_1234, 4'b0000, 32'h0,         32'h0000_8001};
    ops[3]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,         32'h1234_80FF, 4'b0000, 32'h0,         32'hFFFF_FF80};
    ops[4]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,         32'hC300_0000, 4'b0000, 32'h0,         32'h0000_00C3};
    ops[5]  = '{1'b0, 2'b01, 1'b1, 32'h500, 32'h0,         32'hFFFF_7FFE, 4'b0000, 32'h0,         32'h0000_7FFE};
    ops[6]  = '{1'b0, 2'b10, 1'b1, 32'h604, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    ops[7]  = '{1'b0, 2'b11, 1'b0, 32'h607, 32'h0,         32'h0102_0304, 4'b0000, 32'h0,         32'h0102_0304};
    ops[8]  = '{1'b1, 2'b01, 1'b0, 32'h306, 32'h0000_BEEF, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0};
    ops[9]  = '{1'b1, 2'b10, 1'b0, 32'h40B, 32'h1234_5678, 32'h0,         4'b1111, 32'h1234_5678, 32'h0};
    ops[10] = '{1'b1, 2'b00, 1'b0, 32'h300, 32'h1234_56CD, 32'h0,         4'b0001, 32'hCDCD_CDCD, 32'h0};

    // Reset values
    @(negedge clk);
    check("rst_ctrl", {27'b0, ext_valid, ext_write, fetch_ready, mem_ready, 1'b0}, 0);
    check("rst_strb", ext_write_strb, 4'b0000);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_load_data", mem_load_data, 0);
    check("rst_ext_address", ext_address, 0);
    check("rst_ext_wdata", ext_write_data, 0);

    // Basic fetch
    fetch_address = 32'h100;
    ext_read_data = 32'h0000_0013;
    reset = 1'b0;
    wait_valid("fetch");
    check("fetch_ext_address", ext_address, 32'h100);
    check("fetch_ext_write", ext_write, 0);
    fq.push_back(32'h0000_0013);
    grant();
    check("fetch_valid_one_cycle", ext_valid, 0);
    @(negedge clk);
    check("fetch_pulse_len", fetch_ready, 0);

    // Loads and stores, memory winning over the pending fetch each time
    for (int i = 0; i < 11; i++) do_mem(ops[i], 0);

    // ext_* held stable while ext_ready is low, inputs scrambled meanwhile
    do_mem(ops[3], 2);

    // Reset during a waiting load aborts it
    mem_load      = 1'b1;
    mem_address   = 32'h700;
    mem_size      = 2'b10;
    ext_read_data = 32'h0000_0055;
    wait_valid("abort");
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("abort_ext_valid", ext_valid, 0);
    mem_load = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_mem_ready", mem_ready, 0);
    end
    check("abort_load_data", mem_load_data, 0);

    // Minimum latency with ext_ready high from the start
    mem_load      = 1'b1;
    mem_address   = 32'h80A;
    mem_size      = 2'b00;
    mem_signed    = 1'b0;
    ext_read_data = 32'hAABB_CCDD;
    ext_ready     = 1'b1;
    fetch_address = 32'h100;
    mq.push_back(32'h0000_00BB);
    reset = 1'b0;
    @(negedge clk);
    check("lat_ext_valid", ext_valid, 1);
    check("lat_ext_address", ext_address, 32'h808);
    @(negedge clk);
    check("lat_mem_ready", mem_ready, 1);
    ext_ready = 1'b0;
    mem_load  = 1'b0;

    // Branch redirect while a fetch waits
    wait_valid("redir");
    check("redir_first_address", ext_address, 32'h100);
    ext_read_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) fetch_address = 32'h200;
      check("redir_hold_address", ext_address, 32'h100);
    end
    grant();
    check("redir_no_pulse", fetch_ready, 0);
    wait_valid("refetch");
    check("refetch_address", ext_address, 32'h200);
    ext_read_data = 32'h0000_0297;
    fq.push_back(32'h0000_0297);
    grant();
    check("refetch_pulse", fetch_ready, 1);

    repeat (3) @(negedge clk);
    check("fetch_queue_empty", fq.size(), 0);
    check("mem_queue_empty", mq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
